// File: rtl/hex_char_rotator.sv
// Scrolling three-digit 7-segment display: rotates character codes C0..C2 across HEX2..HEX0.
// Optional build macro HEX_ROT_BLINK_EN: blink the display while paused instead of freezing it.
module hex_char_rotator #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [9:0] LEDR
);

  localparam int            CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [6:0]    BLANK   = 7'h7F;

  logic [1:0]    sync_meta;  // [1] pause, [0] direction
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    ptr;
  logic [1:0]    ptr_next;
  logic [1:0]    ptr_p1;
  logic [1:0]    ptr_p2;
  logic          paused;
  logic          dir;
  logic          wrap;
  logic          tick;
  logic [6:0]    hex0_q;
  logic [6:0]    hex1_q;
  logic [6:0]    hex2_q;
  logic          unused_sw;

  assign unused_sw = ^SW[7:6];

  function automatic logic [6:0] dec(input logic [1:0] code);
    unique case (code)
      2'b00:   dec = 7'b0100001;  // d
      2'b01:   dec = 7'b0000110;  // E
      2'b10:   dec = 7'b1111001;  // 1
      default: dec = BLANK;
    endcase
  endfunction

  function automatic logic [1:0] char_at(input logic [5:0] chars, input logic [1:0] idx);
    unique case (idx)
      2'd0:    char_at = chars[1:0];
      2'd1:    char_at = chars[3:2];
      default: char_at = chars[5:4];
    endcase
  endfunction

  assign paused = sync_q[1];
  assign dir    = sync_q[0];
  assign wrap   = (cnt == CNT_MAX);
  assign tick   = wrap && !paused;

  // Digit offsets mod 3; ptr+2 mod 3 equals ptr-1 mod 3.
  assign ptr_p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  assign ptr_p2 = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    cnt_next = cnt;
    ptr_next = ptr;
`ifdef HEX_ROT_BLINK_EN
    cnt_next = wrap ? '0 : cnt + 1'b1;
`else
    if (!paused) cnt_next = wrap ? '0 : cnt + 1'b1;
`endif
    if (tick) ptr_next = dir ? ptr_p2 : ptr_p1;
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      sync_meta <= '0;
      sync_q    <= '0;
      cnt       <= '0;
      ptr       <= '0;
      hex0_q    <= BLANK;
      hex1_q    <= BLANK;
      hex2_q    <= BLANK;
    end else begin
      sync_meta <= SW[9:8];
      sync_q    <= sync_meta;
      cnt       <= cnt_next;
      ptr       <= ptr_next;
      hex2_q    <= dec(char_at(SW[5:0], ptr));
      hex1_q    <= dec(char_at(SW[5:0], ptr_p1));
      hex0_q    <= dec(char_at(SW[5:0], ptr_p2));
    end
  end

`ifdef HEX_ROT_BLINK_EN
  logic phase;

  // Paused ticks only toggle the blink phase; leaving pause clears it at once.
  always_ff @(posedge CLOCK_50) begin
    if (RESET)       phase <= 1'b0;
    else if (!paused) phase <= 1'b0;
    else if (wrap)    phase <= ~phase;
  end

  assign HEX0 = phase ? BLANK : hex0_q;
  assign HEX1 = phase ? BLANK : hex1_q;
  assign HEX2 = phase ? BLANK : hex2_q;
`else
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
`endif

  assign LEDR = {sync_q, 6'b000000, ptr};

endmodule

// File: tb/tb_hex_char_rotator.sv
// Directed bench for hex_char_rotator with TICK_DIV=4 and C0='d', C1='E', C2='1'.
module tb_hex_char_rotator;

  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] BL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = 10'b00_00_100100;
  logic [6:0] hex0, hex1, hex2;
  logic [9:0] ledr;

  int total = 0;
  int bad   = 0;

  hex_char_rotator #(.TICK_DIV(4)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .SW      (sw),
    .HEX0    (hex0),
    .HEX1    (hex1),
    .HEX2    (hex2),
    .LEDR    (ledr)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle just after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    total++;
    if ({hex2, hex1, hex0} !== {BL, BL, BL}) begin
      bad++;
      $display("FAIL reset_hex got=%h %h %h want=%h %h %h", hex2, hex1, hex0, BL, BL, BL);
    end
    total++;
    if (ledr !== 10'h000) begin
      bad++;
      $display("FAIL reset_ledr got=%h want=000", ledr);
    end
    rst = 1'b0;
    step(1);  // edge 1 after release
    total++;
    if ({hex2, hex1, hex0} !== {GD, GE, G1}) begin
      bad++;
      $display("FAIL first_glyphs got=%b %b %b want=%b %b %b", hex2, hex1, hex0, GD, GE, G1);
    end
  endtask

  task automatic test_rotation();
    step(2);  // edge 3: no tick yet
    total++;
    if (ledr[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL early_tick ptr got=%0d want=0", ledr[1:0]);
    end
    step(1);  // edge 4: first tick
    total++;
    if (ledr[1:0] !== 2'd1) begin
      bad++;
      $display("FAIL tick1_ptr got=%0d want=1", ledr[1:0]);
    end
    step(1);  // edge 5
    total++;
    if ({hex2, hex1, hex0} !== {GE, G1, GD}) begin
      bad++;
      $display("FAIL rot1_hex got=%b %b %b want=%b %b %b", hex2, hex1, hex0, GE, G1, GD);
    end
    step(3);  // edge 8
    total++;
    if (ledr[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL tick2_ptr got=%0d want=2", ledr[1:0]);
    end
    step(4);  // edge 12
    total++;
    if (ledr[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL wrap_ptr got=%0d want=0", ledr[1:0]);
    end
    step(1);  // edge 13
    total++;
    if ({hex2, hex1, hex0} !== {GD, GE, G1}) begin
      bad++;
      $display("FAIL wrap_hex got=%b %b %b want=%b %b %b", hex2, hex1, hex0, GD, GE, G1);
    end
  endtask

  task automatic test_direction();
    sw[8] = 1'b1;  // cnt=1, ptr=0
    step(2);  // edge 15: synchroniser output high, no tick yet
    total++;
    if (ledr[8] !== 1'b1 || ledr[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL dir_sync got dir=%b ptr=%0d want dir=1 ptr=0", ledr[8], ledr[1:0]);
    end
    step(1);  // edge 16: tick, descending wrap 0 -> 2
    total++;
    if (ledr[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL dir_ptr got=%0d want=2", ledr[1:0]);
    end
    step(1);  // edge 17
    total++;
    if ({hex2, hex1, hex0} !== {G1, GD, GE}) begin
      bad++;
      $display("FAIL dir_hex got=%b %b %b want=%b %b %b", hex2, hex1, hex0, G1, GD, GE);
    end
  endtask

  task automatic test_pause();
    int moved;
    moved = 0;
    sw[9] = 1'b1;  // cnt=1
    step(2);  // edge 19: pause visible, cnt becomes 3 and holds
    total++;
    if (ledr[9] !== 1'b1) begin
      bad++;
      $display("FAIL pause_sync got=%b want=1", ledr[9]);
    end
    for (int i = 0; i < 18; i++) begin  // edges 20..37
      step(1);
      if (ledr[1:0] !== 2'd2 || {hex2, hex1, hex0} !== {G1, GD, GE}) moved++;
    end
    total++;
    if (moved !== 0) begin
      bad++;
      $display("FAIL pause_hold got=%0d moving cycles want=0", moved);
    end
    sw[9] = 1'b0;
    step(2);  // edge 39: release propagated, still paused during that edge
    total++;
    if (ledr[9] !== 1'b0 || ledr[1:0] !== 2'd2) begin
      bad++;
      $display("FAIL release got pause=%b ptr=%0d want pause=0 ptr=2", ledr[9], ledr[1:0]);
    end
    step(1);  // edge 40: held cnt=3 fires at once, descending 2 -> 1
    total++;
    if (ledr[1:0] !== 2'd1) begin
      bad++;
      $display("FAIL resume_tick ptr got=%0d want=1", ledr[1:0]);
    end
  endtask

  task automatic test_reset_during_tick();
    sw[8] = 1'b0;  // ascending by edge 43, so a tick at edge 44 would give ptr=2
    step(3);       // edge 43: cnt=3
    rst = 1'b1;
    step(1);       // edge 44
    total++;
    if (ledr !== 10'h000 || {hex2, hex1, hex0} !== {BL, BL, BL}) begin
      bad++;
      $display("FAIL rst_tick got ledr=%h hex=%h %h %h want ledr=000 hex=7f 7f 7f",
               ledr, hex2, hex1, hex0);
    end
    rst = 1'b0;
    step(3);  // cnt restarted at 0: no tick yet
    total++;
    if (ledr[1:0] !== 2'd0) begin
      bad++;
      $display("FAIL rst_cnt ptr got=%0d want=0", ledr[1:0]);
    end
    step(1);  // fourth edge after release
    total++;
    if (ledr[1:0] !== 2'd1) begin
      bad++;
      $display("FAIL rst_first_tick ptr got=%0d want=1", ledr[1:0]);
    end
  endtask

  task automatic test_char_change();
    sw[5:0] = 6'b000110;  // C0='1', C1='E', C2='d', ptr=1
    step(1);
    total++;
    if ({hex2, hex1, hex0} !== {GE, GD, G1}) begin
      bad++;
      $display("FAIL char_swap got=%b %b %b want=%b %b %b", hex2, hex1, hex0, GE, GD, G1);
    end
    sw[5:0] = 6'b111111;
    step(1);
    total++;
    if ({hex2, hex1, hex0} !== {BL, BL, BL}) begin
      bad++;
      $display("FAIL char_blank got=%h %h %h want=7f 7f 7f", hex2, hex1, hex0);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_direction();
    test_pause();
    test_reset_during_tick();
    test_char_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_char_rotator.md
# hex_char_rotator

Sequential display stage that sits directly downstream of the 2-bit, 3-to-1 character select multiplexer on the DE1-SoC lab board. It takes three 2-bit character codes from the switches and shows them on HEX2..HEX0 as 7-segment glyphs. A prescaled tick rotates the codes across the three digits, turning the static select network into a scrolling "dE1"-style display. Direction and pause come from switches, and LEDs echo the internal state.

## Interface
- TICK_DIV, 50_000_000: CLOCK_50 cycles per rotation tick; legal range is 2 or more.
- CLOCK_50  in  1  board clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- SW  in  10  switch inputs:
  - SW[1:0] is char C0, SW[3:2] is C1, SW[5:4] is C2.
  - SW[8] is direction: 0 means ptr increments, 1 means ptr decrements.
  - SW[9] is pause.
  - SW[7:6] is unused.
- HEX0, HEX1, HEX2  out  7 each  active-low segments, bit order g f e d c b a.
- LEDR  out  10  status:
  - LEDR[1:0] is ptr.
  - LEDR[8] is the synchronised direction.
  - LEDR[9] is the synchronised pause.
  - LEDR[7:2] is 0.

## Operation
- Character decode:
  - 00 = 'd' (7'b0100001)
  - 01 = 'E' (7'b0000110)
  - 10 = '1' (7'b1111001)
  - 11 = blank (7'b1111111)
- SW[9:8] pass through a two-flop synchroniser before use. SW[5:0] are sampled directly into the output registers.
- Prescaler cnt counts 0..TICK_DIV-1 and wraps to 0. tick = (cnt == TICK_DIV-1) and not paused.
- Rotation pointer ptr is in 0..2 and never takes the value 3:
  - Ascending wraps 2 to 0.
  - Descending wraps 0 to 2.
  - Updates only on tick.
- Digit mapping, all indices mod 3:
  - HEX2 = dec(C[ptr])
  - HEX1 = dec(C[ptr+1])
  - HEX0 = dec(C[ptr+2])
- Pause:
  - cnt and ptr hold.
  - On release, counting resumes from the held cnt; no restart.
- Direction change takes effect at the next tick. A change of direction alone never moves ptr.

## Timing
- Reset values:
  - cnt = 0, ptr = 0, synchroniser flops = 0.
  - HEX0..HEX2 = 7'h7F (blank).
  - LEDR = 10'h000.
- RESET has priority over tick, pause and every other event in the same cycle.
- HEX outputs are registered from the current ptr and SW[5:0]:
  - 1-cycle latency from a SW[5:0] change.
  - 1-cycle latency from a ptr update.
- Pause and direction take effect 2 cycles after the SW edge, through the synchroniser.
- First tick after reset release occurs TICK_DIV cycles after the first non-reset edge. Subsequent ticks occur every TICK_DIV unpaused cycles.
- LEDR[1:0] shows ptr with no extra latency. LEDR[9:8] show the synchroniser outputs.

## Configuration
- HEX_ROT_BLINK_EN defined:
  - While paused, cnt keeps running and generates internal ticks.
  - A blink phase flop toggles on each of these ticks; ptr still holds.
  - HEX0..HEX2 are forced to blank whenever phase = 1.
  - phase resets to 0 and is forced to 0 the cycle pause deasserts.
  - On resume, cnt continues from its current value.
- HEX_ROT_BLINK_EN undefined:
  - No phase flop.
  - cnt freezes during pause and the display is steady.

## Test plan
All tests use TICK_DIV=4 and SW[5:0]=6'b100100, so C0='d', C1='E', C2='1'.
- Reset test:
  - Stimulus: RESET=1 for 2 cycles.
  - Response: HEX2..HEX0 = 7F/7F/7F and LEDR = 0 during reset. On the first edge after release, HEX2/1/0 = 0100001 / 0000110 / 1111001.
- Rotation test:
  - Stimulus: run 4 cycles after release.
  - Response: LEDR[1:0]=1, then next cycle HEX2/1/0 = E/1/d. ptr reaches 2 after 8 cycles and 0 after 12 cycles, where the display shows d/E/1 again.
- Direction test:
  - Stimulus: SW[8]=1 at ptr=0.
  - Response: ptr stays 0 until the next tick, then becomes 2. The display shows 1/d/E.
- Pause test:
  - Stimulus: assert SW[9]=1 at cnt=1, hold 20 cycles, then release.
  - Response: ptr unchanged throughout. The next tick arrives exactly 2 + (3-held cnt) cycles after release propagates. In the build without HEX_ROT_BLINK_EN, the display is steady during the pause.
- Reset during tick:
  - Stimulus: assert RESET in the cycle where cnt=3.
  - Response: ptr=0, cnt=0, display blank the next cycle. No rotation.
- Blink test, HEX_ROT_BLINK_EN defined:
  - Stimulus: pause for 16 cycles.
  - Response: HEX toggles blank/glyphs every 4 cycles with ptr constant. On unpause, glyphs show within 1 cycle.
